// File: rtl/controller_pipe_pkg.sv
// Shared opcode/funct constants, ALU control codes, FSM state codes and the
// ID-stage control bundle for controller_pipe.
package controller_pipe_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_ZERO   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_NOP    = 5'd0;
  localparam logic [4:0] ALU_ADD    = 5'd1;
  localparam logic [4:0] ALU_SUB    = 5'd2;
  localparam logic [4:0] ALU_SUBU   = 5'd3;
  localparam logic [4:0] ALU_AND    = 5'd4;
  localparam logic [4:0] ALU_OR     = 5'd5;
  localparam logic [4:0] ALU_XOR    = 5'd6;
  localparam logic [4:0] ALU_SLL    = 5'd7;
  localparam logic [4:0] ALU_SRL    = 5'd8;
  localparam logic [4:0] ALU_SRA    = 5'd9;
  localparam logic [4:0] ALU_SLT    = 5'd10;
  localparam logic [4:0] ALU_SLTU   = 5'd11;
  // M codes follow funct3 order so bit 4 alone marks an M-op
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam logic [4:0] IMM_I = 5'b10000;
  localparam logic [4:0] IMM_S = 5'b01000;
  localparam logic [4:0] IMM_B = 5'b00100;
  localparam logic [4:0] IMM_U = 5'b00010;
  localparam logic [4:0] IMM_J = 5'b00001;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic [4:0] aluctrl;
    logic [1:0] alusrca;
    logic       alusrcb;
    logic       memwrite;
    logic [3:0] swhb;
    logic [1:0] lwhb;
    logic       lunsigned;
    logic       memtoreg;
    logic       regwrite;
    logic       jal;
    logic       jalr;
  } ctrl_t;

  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  alu_base = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_base = ALU_SLL;
      F3_SLT:  alu_base = ALU_SLT;
      F3_SLTU: alu_base = ALU_SLTU;
      F3_XOR:  alu_base = ALU_XOR;
      F3_SR:   alu_base = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_base = ALU_OR;
      F3_AND:  alu_base = ALU_AND;
      default: alu_base = ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(M) decoder: opcode/funct fields to control bundle.
// M-extension encodings decode only when RV32M_EN is defined.
module ctrl_decode
  import controller_pipe_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic [4:0] immctrl,
  output logic [3:0] btypesig,
  output logic       bunsigned,
  output logic       illegal
);

  ctrl_t      c;
  logic [4:0] imm;
  logic [3:0] bt;
  logic       bu;
  logic       bad;

  // main decode; undecodable encodings raise bad and are zeroed below
  always_comb begin
    c   = '0;
    imm = 5'b0;
    bt  = 4'b0;
    bu  = 1'b0;
    bad = 1'b0;
    case (opcode)
      OP_LUI:   begin imm = IMM_U; c.aluctrl = ALU_ADD; c.alusrca = 2'b01; c.alusrcb = 1'b1; c.regwrite = 1'b1; end
      OP_AUIPC: begin imm = IMM_U; c.aluctrl = ALU_ADD; c.alusrca = 2'b10; c.alusrcb = 1'b1; c.regwrite = 1'b1; end
      OP_JAL:   begin imm = IMM_J; c.aluctrl = ALU_ADD; c.alusrca = 2'b10; c.alusrcb = 1'b1; c.regwrite = 1'b1; c.jal = 1'b1; end
      OP_JALR: begin
        imm = IMM_I; c.aluctrl = ALU_ADD; c.alusrcb = 1'b1; c.regwrite = 1'b1; c.jalr = 1'b1;
        bad = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        imm = IMM_B;
        case (funct3)
          3'b000:  bt = 4'b0001;
          3'b001:  bt = 4'b0010;
          3'b100:  bt = 4'b0100;
          3'b101:  bt = 4'b1000;
          3'b110:  begin bt = 4'b0100; bu = 1'b1; end
          3'b111:  begin bt = 4'b1000; bu = 1'b1; end
          default: bad = 1'b1;
        endcase
        c.aluctrl = bu ? ALU_SUBU : ALU_SUB;
      end
      OP_LOAD: begin
        imm = IMM_I; c.aluctrl = ALU_ADD; c.alusrcb = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1;
        case (funct3)
          3'b000:  c.lwhb = 2'b01;
          3'b001:  c.lwhb = 2'b10;
          3'b010:  c.lwhb = 2'b00;
          3'b100:  begin c.lwhb = 2'b01; c.lunsigned = 1'b1; end
          3'b101:  begin c.lwhb = 2'b10; c.lunsigned = 1'b1; end
          default: bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        imm = IMM_S; c.aluctrl = ALU_ADD; c.alusrcb = 1'b1; c.memwrite = 1'b1;
        case (funct3)
          3'b000:  c.swhb = 4'b0001;
          3'b001:  c.swhb = 4'b0011;
          3'b010:  c.swhb = 4'b1111;
          default: bad = 1'b1;
        endcase
      end
      OP_IMM: begin
        imm = IMM_I; c.alusrcb = 1'b1; c.regwrite = 1'b1;
        c.aluctrl = alu_base(funct3, (funct3 == F3_SR) && (funct7 == FUNCT7_ALT));
        if (funct3 == F3_SLL) begin
          bad = (funct7 != FUNCT7_ZERO);
        end else if (funct3 == F3_SR) begin
          bad = (funct7 != FUNCT7_ZERO) && (funct7 != FUNCT7_ALT);
        end else begin
          bad = 1'b0;
        end
      end
      OP_OP: begin
        c.regwrite = 1'b1;
        if (funct7 == FUNCT7_ZERO) begin
          c.aluctrl = alu_base(funct3, 1'b0);
        end else if (funct7 == FUNCT7_ALT) begin
          c.aluctrl = alu_base(funct3, 1'b1);
          bad = (funct3 != F3_ADD) && (funct3 != F3_SR);
        end else if (funct7 == FUNCT7_MULDIV) begin
`ifdef RV32M_EN
          c.aluctrl = {2'b10, funct3};
`else
          bad = 1'b1;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  assign ctrl      = bad ? '0 : c;
  assign immctrl   = bad ? 5'b0 : imm;
  assign btypesig  = bad ? 4'b0 : bt;
  assign bunsigned = bad ? 1'b0 : bu;
  assign illegal   = bad;

endmodule

// File: rtl/controller_pipe.sv
// Pipeline control unit: ID decode, ID/EX control register with stall/flush,
// and (with RV32M_EN defined) the multi-cycle M-op occupancy FSM.
module controller_pipe
  import controller_pipe_pkg::*;
#(
  parameter int RFIDX_WIDTH = 5,
  parameter int ALUCTRL_W   = 5,
  parameter int MD_LAT      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instr_id,
  input  logic                   id_valid,
  input  logic                   stall_in,
  input  logic                   flush_in,
  output logic [4:0]             immctrl,
  output logic [3:0]             btypesig,
  output logic                   bunsigned,
  output logic                   illegal_id,
  output logic                   ex_valid,
  output logic [ALUCTRL_W-1:0]   ex_aluctrl,
  output logic [1:0]             ex_alusrca,
  output logic                   ex_alusrcb,
  output logic                   ex_memwrite,
  output logic [3:0]             ex_swhb,
  output logic [1:0]             ex_lwhb,
  output logic                   ex_lunsigned,
  output logic                   ex_memtoreg,
  output logic                   ex_regwrite,
  output logic                   ex_jal,
  output logic                   ex_jalr,
  output logic [RFIDX_WIDTH-1:0] ex_rd,
  output logic                   ex_is_md,
  output logic                   md_done,
  output logic                   stall_out
);

  ctrl_t      dec_ctrl;
  ctrl_t      load_ctrl;
  ctrl_t      ex_ctrl;
  logic [4:0] dec_imm;
  logic [3:0] dec_bt;
  logic       dec_bu;
  logic       dec_bad;
  logic       hold;
  logic       bubble;
  logic       flush_pend;
  logic       unused_bits;

  ctrl_decode u_decode (
    .opcode    (instr_id[6:0]),
    .funct3    (instr_id[14:12]),
    .funct7    (instr_id[31:25]),
    .ctrl      (dec_ctrl),
    .immctrl   (dec_imm),
    .btypesig  (dec_bt),
    .bunsigned (dec_bu),
    .illegal   (dec_bad)
  );

  assign immctrl    = id_valid ? dec_imm : 5'b0;
  assign btypesig   = id_valid ? dec_bt : 4'b0;
  assign bunsigned  = id_valid & dec_bu;
  assign illegal_id = id_valid & dec_bad;

  assign hold   = stall_out | stall_in;
  assign bubble = flush_in | flush_pend | ~id_valid | illegal_id;
  assign unused_bits = ^{instr_id[24:15], 1'(MD_LAT)};

  // writes to x0 are dropped but the instruction stays valid
  always_comb begin
    load_ctrl = dec_ctrl;
    load_ctrl.regwrite = dec_ctrl.regwrite & (instr_id[11:7] != 5'd0);
  end

  // ID/EX control register: reset > hold > bubble > load
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      ex_ctrl  <= '0;
    end else if (hold) begin
      ex_valid <= ex_valid;
      ex_rd    <= ex_rd;
      ex_ctrl  <= ex_ctrl;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_rd    <= RFIDX_WIDTH'(instr_id[11:7]);
      ex_ctrl  <= load_ctrl;
    end
  end

  // a flush arriving while an M-op holds the front end is remembered
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pend <= 1'b0;
    end else if (!hold) begin
      flush_pend <= 1'b0;
    end else if (flush_in && stall_out) begin
      flush_pend <= 1'b1;
    end else begin
      flush_pend <= flush_pend;
    end
  end

  assign ex_aluctrl   = ALUCTRL_W'(ex_ctrl.aluctrl);
  assign ex_alusrca   = ex_ctrl.alusrca;
  assign ex_alusrcb   = ex_ctrl.alusrcb;
  assign ex_memwrite  = ex_ctrl.memwrite;
  assign ex_swhb      = ex_ctrl.swhb;
  assign ex_lwhb      = ex_ctrl.lwhb;
  assign ex_lunsigned = ex_ctrl.lunsigned;
  assign ex_memtoreg  = ex_ctrl.memtoreg;
  assign ex_regwrite  = ex_ctrl.regwrite;
  assign ex_jal       = ex_ctrl.jal;
  assign ex_jalr      = ex_ctrl.jalr;

`ifdef RV32M_EN
  localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             load_md;

  assign load_md = ~hold & ~bubble & dec_ctrl.aluctrl[4];

  // BUSY covers the first MD_LAT-1 EX cycles; the final one runs in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (state == ST_BUSY) begin
      if (cnt == CNT_W'(1)) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        state <= ST_BUSY;
        cnt   <= cnt - CNT_W'(1);
      end
    end else if (load_md && (MD_LAT > 1)) begin
      state <= ST_BUSY;
      cnt   <= CNT_W'(MD_LAT - 1);
    end else begin
      state <= state;
      cnt   <= cnt;
    end
  end

  assign stall_out = (state == ST_BUSY);
  assign ex_is_md  = ex_ctrl.aluctrl[4];
  assign md_done   = ex_valid & ex_is_md & (state == ST_IDLE);
`else
  assign stall_out = 1'b0;
  assign ex_is_md  = 1'b0;
  assign md_done   = 1'b0;
`endif

endmodule

// File: tb/tb_controller_pipe.sv
// Randomized self-checking bench for controller_pipe against a cycle-level
// reference model; directed M-op sequences run when RV32M_EN is defined.
module tb_controller_pipe;
  import controller_pipe_pkg::*;

  localparam int MD_LAT = 4;

  typedef struct packed {
    logic [4:0] alu;
    logic [1:0] srca;
    logic       srcb;
    logic       mw;
    logic [3:0] swhb;
    logic [1:0] lwhb;
    logic       lu;
    logic       m2r;
    logic       rw;
    logic       jal;
    logic       jalr;
    logic [4:0] imm;
    logic [3:0] bt;
    logic       bu;
    logic       bad;
  } dec_t;

  logic        clk = 1'b0;
  logic        reset, id_valid, stall_in, flush_in;
  logic [31:0] instr_id;
  logic [4:0]  immctrl;
  logic [3:0]  btypesig;
  logic        bunsigned, illegal_id, ex_valid, ex_alusrcb, ex_memwrite;
  logic [4:0]  ex_aluctrl;
  logic [1:0]  ex_alusrca, ex_lwhb;
  logic [3:0]  ex_swhb;
  logic        ex_lunsigned, ex_memtoreg, ex_regwrite, ex_jal, ex_jalr;
  logic [4:0]  ex_rd;
  logic        ex_is_md, md_done, stall_out;

  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state: EX slot contents and remaining M-op occupancy
  logic       m_valid;
  dec_t       m_d;
  logic [4:0] m_rd;
  logic       m_md;
  int         m_rem;
  logic       m_pend;

  controller_pipe #(.RFIDX_WIDTH(5), .ALUCTRL_W(5), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid),
    .stall_in(stall_in), .flush_in(flush_in), .immctrl(immctrl),
    .btypesig(btypesig), .bunsigned(bunsigned), .illegal_id(illegal_id),
    .ex_valid(ex_valid), .ex_aluctrl(ex_aluctrl), .ex_alusrca(ex_alusrca),
    .ex_alusrcb(ex_alusrcb), .ex_memwrite(ex_memwrite), .ex_swhb(ex_swhb),
    .ex_lwhb(ex_lwhb), .ex_lunsigned(ex_lunsigned), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_rd(ex_rd), .ex_is_md(ex_is_md), .md_done(md_done), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] alu_ref(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic dec_t ref_dec(input logic [31:0] ins);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    d = '0; f3 = ins[14:12]; f7 = ins[31:25]; ok = 1'b0;
    case (ins[6:0])
      7'h37: begin d.imm = 5'b00010; d.alu = ALU_ADD; d.srca = 2'b01; d.srcb = 1'b1; d.rw = 1'b1; ok = 1'b1; end
      7'h17: begin d.imm = 5'b00010; d.alu = ALU_ADD; d.srca = 2'b10; d.srcb = 1'b1; d.rw = 1'b1; ok = 1'b1; end
      7'h6F: begin d.imm = 5'b00001; d.alu = ALU_ADD; d.srca = 2'b10; d.srcb = 1'b1; d.rw = 1'b1; d.jal = 1'b1; ok = 1'b1; end
      7'h67: begin d.imm = 5'b10000; d.alu = ALU_ADD; d.srcb = 1'b1; d.rw = 1'b1; d.jalr = 1'b1; ok = (f3 == 3'd0); end
      7'h63: begin
        d.imm = 5'b00100; d.bt = 4'b0001 << {f3[2], f3[0]}; d.bu = f3[1];
        d.alu = f3[1] ? ALU_SUBU : ALU_SUB; ok = f3[2] | ~f3[1];
      end
      7'h03: begin
        d.imm = 5'b10000; d.alu = ALU_ADD; d.srcb = 1'b1; d.m2r = 1'b1; d.rw = 1'b1;
        d.lwhb = (f3[1:0] == 2'd0) ? 2'b01 : (f3[1:0] == 2'd1) ? 2'b10 : 2'b00;
        d.lu = f3[2]; ok = (f3[1:0] != 2'd3) && !(f3[2] && f3[1]);
      end
      7'h23: begin
        d.imm = 5'b01000; d.alu = ALU_ADD; d.srcb = 1'b1; d.mw = 1'b1;
        d.swhb = 4'((1 << (1 << f3)) - 1); ok = (f3 < 3'd3);
      end
      7'h13: begin
        d.imm = 5'b10000; d.srcb = 1'b1; d.rw = 1'b1;
        d.alu = alu_ref(f3, (f3 == 3'd5) && (f7 == 7'h20));
        ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      end
      7'h33: begin
        d.rw = 1'b1;
        if (f7 == 7'h00) begin d.alu = alu_ref(f3, 1'b0); ok = 1'b1; end
        else if (f7 == 7'h20) begin d.alu = alu_ref(f3, 1'b1); ok = (f3 == 3'd0) || (f3 == 3'd5); end
        else if (f7 == 7'h01) begin
          d.alu = 5'(ALU_MUL + f3);
`ifdef RV32M_EN
          ok = 1'b1;
`else
          ok = 1'b0;
`endif
        end
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin d = '0; d.bad = 1'b1; end
    return d;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_d = '0; m_rd = 5'd0; m_md = 1'b0; m_rem = 0; m_pend = 1'b0;
  endtask

  // one clock: drive, compare everything, clock edge, advance the model
  task automatic cyc(input logic rst, input logic iv, input logic [31:0] ins,
                     input logic si, input logic fl);
    dec_t d;
    logic so, held;
    reset = rst; id_valid = iv; instr_id = ins; stall_in = si; flush_in = fl;
    #2;
    d  = ref_dec(ins);
    so = m_valid && m_md && (m_rem > 1);
    check_eq("id_outputs", 32'({immctrl, btypesig, bunsigned, illegal_id}),
             iv ? 32'({d.imm, d.bt, d.bu, d.bad}) : 32'd0);
    check_eq("ex_bundle",
             32'({ex_valid, ex_aluctrl, ex_alusrca, ex_alusrcb, ex_memwrite, ex_swhb, ex_lwhb,
                  ex_lunsigned, ex_memtoreg, ex_regwrite, ex_jal, ex_jalr, ex_rd, ex_is_md}),
             32'({m_valid, m_d.alu, m_d.srca, m_d.srcb, m_d.mw, m_d.swhb, m_d.lwhb,
                  m_d.lu, m_d.m2r, m_d.rw, m_d.jal, m_d.jalr, m_rd, m_md}));
    check_eq("stall_out", 32'(stall_out), 32'(so));
    check_eq("md_done", 32'(md_done), 32'(m_valid && m_md && (m_rem == 1)));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      held = so | si;
      if (held) begin
        if (so && fl) m_pend = 1'b1;
        if (so) m_rem--;
      end else if (fl || m_pend || !iv || d.bad) begin
        m_pend = 1'b0; m_valid = 1'b0; m_d = '0; m_rd = 5'd0; m_md = 1'b0; m_rem = 0;
      end else begin
        m_pend = 1'b0; m_valid = 1'b1; m_d = d; m_rd = ins[11:7];
        m_d.imm = 5'd0; m_d.bt = 4'd0; m_d.bu = 1'b0; m_d.bad = 1'b0;
        m_d.rw = d.rw && (ins[11:7] != 5'd0);
        m_md = (d.alu >= ALU_MUL);
        m_rem = m_md ? MD_LAT : 0;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: ins[6:0] = 7'h37;
      1: ins[6:0] = 7'h17;
      2: ins[6:0] = 7'h6F;
      3: begin ins[6:0] = 7'h67; if ($urandom_range(0, 1) == 0) ins[14:12] = 3'd0; end
      4: ins[6:0] = 7'h63;
      5: ins[6:0] = 7'h03;
      6: ins[6:0] = 7'h23;
      7: ins[6:0] = 7'h13;
      8: ins[6:0] = 7'h33;
      default: ins[6:0] = ins[6:0];
    endcase
    if (ins[6:0] == 7'h13 || ins[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        2: ins[31:25] = 7'h01;
        default: ins[31:25] = ins[31:25];
      endcase
    end
    if ($urandom_range(0, 9) == 0) ins[11:7] = 5'd0;
    return ins;
  endfunction

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_ADD  = 32'h00208233;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_DIV  = 32'h027342B3;

  initial begin
    int n_stall;
    reset = 1'b1; id_valid = 1'b0; instr_id = 32'd0; stall_in = 1'b0; flush_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("reset_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("reset_stall", 32'(stall_out), 32'd0);

    cyc(1'b0, 1'b1, I_ADDI, 1'b0, 1'b0);
    check_eq("addi_fields", 32'({ex_valid, ex_rd, ex_regwrite, ex_alusrcb}), 32'({1'b1, 5'd1, 1'b1, 1'b1}));
    check_eq("addi_alu", 32'(ex_aluctrl), 32'(ALU_ADD));

    cyc(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    check_eq("illegal_bubble", 32'(ex_valid), 32'd0);

    cyc(1'b0, 1'b1, I_ADD, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, I_SW, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, I_SW, 1'b1, 1'b0);
    check_eq("stall_hold_rd", 32'({ex_rd, ex_regwrite, ex_memwrite}), 32'({5'd4, 1'b1, 1'b0}));
    cyc(1'b0, 1'b1, I_SW, 1'b0, 1'b0);
    check_eq("sw_swhb", 32'({ex_swhb, ex_memwrite, ex_regwrite}), 32'({4'b1111, 1'b1, 1'b0}));

`ifdef RV32M_EN
    cyc(1'b0, 1'b1, I_MUL, 1'b0, 1'b0);
    n_stall = 0;
    for (int i = 0; i < 6; i++) begin
      if (stall_out) n_stall++;
      cyc(1'b0, 1'b1, I_ADD, 1'b0, 1'b0);
    end
    check_eq("mul_stall_cycles", 32'(n_stall), 32'(MD_LAT - 1));

    cyc(1'b0, 1'b1, I_MUL, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, I_ADD, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, I_ADD, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, I_ADD, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, I_ADD, 1'b0, 1'b0);
    check_eq("flush_pend_bubble", 32'(ex_valid), 32'd0);
    cyc(1'b0, 1'b1, I_ADD, 1'b0, 1'b0);

    cyc(1'b0, 1'b1, I_DIV, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, I_ADD, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, I_ADD, 1'b0, 1'b0);
    check_eq("reset_abort", 32'({stall_out, ex_valid, md_done}), 32'd0);
`else
    n_stall = 0;
    cyc(1'b0, 1'b1, I_MUL, 1'b0, 1'b0);
    check_eq("no_m_bubble", 32'({ex_valid, stall_out, ex_is_md}), 32'({3'd0, 5'(n_stall)}));
`endif

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, rand_instr(),
          $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controller_pipe.md
Name: controller_pipe

Overview:
Parametrised next-generation RV32I(M) control unit for the 5-stage pipeline. It decodes the ID-stage instruction combinationally and registers the control bundle into the ID/EX boundary, honouring stall, flush and bubble insertion. It also runs a multi-cycle FSM that holds a MUL/DIV instruction in EX for MD_LAT cycles and stalls the front end while it does so. Branch resolution stays in ID through btypesig; the comparator is external.

Parameters:
RFIDX_WIDTH, 5, register-index width.
ALUCTRL_W, 5, width of aluctrl; widened so the M-extension op codes fit.
MD_LAT, 4, total EX-occupancy cycles for any M-op; must be ≥1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
instr_id  in  32  ID-stage instruction
id_valid  in  1  instr_id holds a real instruction
stall_in  in  1  hazard-unit stall: hold the ID/EX register
flush_in  in  1  kill the ID instruction (taken branch/jump)
immctrl  out  5  ID immediate select, encoding {I|shift, S|shift, B, U, J}
btypesig  out  4  ID branch type, encoding {bge/bgeu, blt/bltu, bne, beq}
bunsigned  out  1  ID: bltu/bgeu
illegal_id  out  1  ID: undecodable opcode/funct while id_valid
ex_valid  out  1  EX slot holds a live instruction
ex_aluctrl  out  ALUCTRL_W  ALU operation
ex_alusrca  out  2  operand A select: 00 rs1, 01 zero (lui), 10 pc (auipc)
ex_alusrcb  out  1  operand B select: immediate
ex_memwrite  out  1  store
ex_swhb  out  4  store byte-enable mask
ex_lwhb  out  2  load size, encoding {half, byte}
ex_lunsigned  out  1  unsigned load
ex_memtoreg  out  1  load result to register file
ex_regwrite  out  1  register-file write
ex_jal, ex_jalr  out  1 each  link write of pc+4
ex_rd  out  RFIDX_WIDTH  destination register
ex_is_md  out  1  EX holds an M-op
md_done  out  1  last EX cycle of an M-op
stall_out  out  1  M-op busy: front end and ID/EX must hold

Behaviour:
- Reset is synchronous and active-high: all ex_* outputs are 0, the FSM is IDLE, cnt=0, flush_pend=0. Reset asserted mid-BUSY aborts the M-op; the next cycle shows stall_out=0 and ex_valid=0.
- ID outputs (immctrl, btypesig, bunsigned, illegal_id) are purely combinational from instr_id and are gated by id_valid.
- ID/EX register update priority, evaluated at each edge:
  1. reset;
  2. stall_out or stall_in: hold;
  3. flush_in, flush_pend, !id_valid or illegal_id: load a bubble (all controls 0, ex_valid=0);
  4. otherwise load the decoded bundle.
- ex_regwrite is forced to 0 when rd=x0. The instruction still counts as valid.
- flush_in while stall_out=1 sets flush_pend. flush_pend is consumed by the first non-held edge, which loads a bubble, and is then cleared.
- M-op FSM, states IDLE and BUSY, counter cnt:
  - An edge that loads an M-op with MD_LAT>1 sets cnt=MD_LAT-1 and goes to BUSY.
  - In BUSY, cnt decrements each cycle; when cnt==1 the FSM goes to IDLE with cnt=0.
  - stall_out = (state==BUSY).
  - md_done = ex_valid & ex_is_md & IDLE.
  - The M-op therefore occupies EX for exactly MD_LAT cycles, with stall_out high for the first MD_LAT-1 of them.
- MD_LAT=1: the FSM never leaves IDLE and md_done is high on the single EX cycle.
- Back-to-back M-ops: the edge ending one M-op may load the next and re-enter BUSY with no gap cycle.
- stall_in during BUSY has no additional effect. The counter keeps running.
- M-op aluctrl codes: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- RV32I aluctrl codes:
  - shifts are distinguished by funct7;
  - branches use SUB/SUBU;
  - load, store, lui, auipc and jalr use ADD.

Optional Feature:
RV32M_EN.
- Defined: OP 0110011 with funct7 0000001 decodes to the M-ops, and the FSM is present.
- Undefined: that encoding sets illegal_id, the FSM is not built, and stall_out, ex_is_md and md_done are tied to 0.

Decomposition:
- xgriscv_defines.v gets: opcode, funct3 and funct7 constants including FUNCT7_MULDIV; the ALUCTRL_W-wide ALU_CTRL_* codes including the eight M codes; FSM state encodings.
- One sub-module, ctrl_decode, is the combinational decoder: instr → control bundle plus illegal flag.
- controller_pipe wraps ctrl_decode and adds the ID/EX register, flush_pend and the M-op FSM.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with id_valid=1 → next cycle ex_valid=1, ex_rd=1, ex_regwrite=1, ex_alusrcb=1, ex_aluctrl=ADD.
- mul x3,x1,x2 (0x022081B3), MD_LAT=4 → stall_out=1 for 3 cycles, ex_rd=3 held 4 cycles, md_done=1 on the 4th; a following add is loaded on the 5th.
- flush_in pulsed in the 2nd BUSY cycle → when BUSY ends, a bubble is loaded (ex_valid=0) and the held ID instruction never reaches EX.
- instr 0xFFFFFFFF → illegal_id=1, next cycle ex_valid=0. Separately, sw x2,0(x1) with stall_in=1 for 2 cycles → ex_* unchanged during the stall, then loaded with ex_swhb=4'b1111.
- reset asserted in the 2nd BUSY cycle of div x5,x6,x7 (0x027342B3) → next cycle stall_out=0, ex_valid=0, md_done=0.
- Build without RV32M_EN: 0x022081B3 → illegal_id=1, stall_out stays 0, bubble loaded.
